dram_rmw_ctrl: RTL and testbench

Read-modify-write sequencer sitting directly upstream of the DRAM bridge. It accepts one record operation at a time from the main datapath and drives the bridge's C-side interface (C_in_valid/C_r_wb/C_addr/C_data_w in, C_out_valid/C_data_r back). For update operations it reads the 64-bit record, applies the field update, and writes it back. It then returns the final record and a status code.

---
 rtl/dram_rmw_if.sv | 35 +++
 rtl/dram_rmw_ctrl.sv | 147 ++++++++++++++
 tb/tb_dram_rmw_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dram_rmw_if.sv
// dram_rmw_if: request/response and bridge C-side bundle for dram_rmw_ctrl
//   req_*  : record operation request (valid/ready, op, addr, four-field delta)
//   resp_* : one-cycle result pulse with final record and status
//   C_*    : single-outstanding command/completion channel to the DRAM bridge
//   master : controller side; slave : requester + bridge side
interface dram_rmw_if #(
    parameter int FLD_W = 12
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [7:0]           req_addr;
    logic [4*FLD_W-1:0]   req_delta;
    logic                 resp_valid;
    logic [63:0]          resp_data;
    logic [1:0]           resp_err;
    logic                 C_in_valid;
    logic                 C_r_wb;
    logic [7:0]           C_addr;
    logic [63:0]          C_data_w;
    logic                 C_out_valid;
    logic [63:0]          C_data_r;

    modport master (
        input  req_valid, req_op, req_addr, req_delta, C_out_valid, C_data_r,
        output req_ready, resp_valid, resp_data, resp_err,
               C_in_valid, C_r_wb, C_addr, C_data_w
    );

    modport slave (
        output req_valid, req_op, req_addr, req_delta, C_out_valid, C_data_r,
        input  req_ready, resp_valid, resp_data, resp_err,
               C_in_valid, C_r_wb, C_addr, C_data_w
    );
endinterface

// File: rtl/dram_rmw_ctrl.sv
// dram_rmw_ctrl: read-modify-write sequencer in front of the DRAM bridge
//   clk, rst : clock and asynchronous active-high reset
//   bus      : dram_rmw_if.master (request, response, bridge C-side)
// Record layout: f0=[63:52] f1=[51:40] f2=[39:28] f3=[27:16], [15:0] passthrough.
module dram_rmw_ctrl #(
    parameter int FLD_W   = 12,
    parameter int FLD_MAX = 4095
) (
    input  logic       clk,
    input  logic       rst,
    dram_rmw_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ, WR_WAIT, RESP} state_t;

    localparam logic [1:0]       OP_ADD = 2'd1;
    localparam logic [1:0]       OP_SUB = 2'd2;
    localparam logic [FLD_W-1:0] MAX    = FLD_W'(FLD_MAX);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [7:0]         addr_q, addr_d;
    logic [4*FLD_W-1:0] delta_q, delta_d;
    logic [63:0]        rec_q, rec_d;
    logic [1:0]         err_q, err_d;

    logic               req_ready_q;
    logic               c_in_valid_q, c_r_wb_q;
    logic [7:0]         c_addr_q;
    logic [63:0]        c_data_w_q;
    logic               resp_valid_q;
    logic [63:0]        resp_data_q;
    logic [1:0]         resp_err_q;

    logic [FLD_W-1:0]   f, d;
    logic [FLD_W:0]     sum;
    logic               ovf, insuf;
    logic [63:0]        add_rec, sub_rec;

    // Both candidate records are formed every cycle; CALC picks one by op.
    always_comb begin
        f       = '0;
        d       = '0;
        sum     = '0;
        ovf     = 1'b0;
        insuf   = 1'b0;
        add_rec = rec_q;
        sub_rec = rec_q;
        for (int i = 0; i < 4; i++) begin
            f     = rec_q[63-i*FLD_W -: FLD_W];
            d     = delta_q[4*FLD_W-1-i*FLD_W -: FLD_W];
            sum   = {1'b0, f} + {1'b0, d};
            ovf   = ovf | (sum > {1'b0, MAX});
            insuf = insuf | (f < d);
            add_rec[63-i*FLD_W -: FLD_W] = (sum > {1'b0, MAX}) ? MAX : sum[FLD_W-1:0];
            sub_rec[63-i*FLD_W -: FLD_W] = f - d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        delta_d = delta_q;
        rec_d   = rec_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = RD_REQ;
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    delta_d = bus.req_delta;
                    err_d   = 2'd0;
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: begin
                if (bus.C_out_valid) begin
                    rec_d   = bus.C_data_r;
                    state_d = (op_q == OP_ADD || op_q == OP_SUB) ? CALC : RESP;
                end
            end
            CALC: begin
                if (op_q == OP_ADD) begin
                    rec_d   = add_rec;
                    err_d   = ovf ? 2'd1 : 2'd0;
                    state_d = WR_REQ;
                end else if (insuf) begin
                    err_d   = 2'd2;
                    state_d = RESP;
                end else begin
                    rec_d   = sub_rec;
                    state_d = WR_REQ;
                end
            end
            WR_REQ:  state_d = WR_WAIT;
            WR_WAIT: state_d = bus.C_out_valid ? RESP : WR_WAIT;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they belong to without an extra cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            delta_q      <= '0;
            rec_q        <= '0;
            err_q        <= '0;
            req_ready_q  <= 1'b1;
            c_in_valid_q <= 1'b0;
            c_r_wb_q     <= 1'b0;
            c_addr_q     <= '0;
            c_data_w_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            delta_q      <= delta_d;
            rec_q        <= rec_d;
            err_q        <= err_d;
            req_ready_q  <= state_d == IDLE;
            c_in_valid_q <= state_d == RD_REQ || state_d == WR_REQ;
            c_r_wb_q     <= state_d == RD_REQ;
            c_addr_q     <= (state_d == RD_REQ || state_d == WR_REQ) ? addr_d : '0;
            c_data_w_q   <= (state_d == WR_REQ) ? rec_d : '0;
            resp_valid_q <= state_d == RESP;
            resp_data_q  <= (state_d == RESP) ? rec_d : '0;
            resp_err_q   <= (state_d == RESP) ? err_d : '0;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.C_in_valid = c_in_valid_q;
    assign bus.C_r_wb     = c_r_wb_q;
    assign bus.C_addr     = c_addr_q;
    assign bus.C_data_w   = c_data_w_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dram_rmw_ctrl.sv
// tb_dram_rmw_ctrl: randomized bench with a record-level model and bridge memory
module tb_dram_rmw_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_rmw_if bus();
    dram_rmw_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { bit rd; logic [7:0] a; logic [63:0] d; } cmd_t;
    typedef struct { logic [63:0] d; logic [1:0] e; } rsp_t;

    cmd_t        cq[$];
    rsp_t        rq[$];
    logic [63:0] mem [256];
    int          cidx = 0, ridx = 0;
    int          n_cmp = 0, n_bad = 0;
    int          acc_cnt = 0, rsp_cnt = 0, cmd_cnt = 0;
    int          rd_lat = 1, wr_lat = 1;
    logic [63:0] last_data;
    logic [1:0]  last_err;
    logic        c_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Record-level semantics: four 12-bit counters, saturating add, all-or-nothing subtract.
    function automatic void model(input logic [1:0] op, input logic [63:0] rec, input logic [47:0] dl,
                                  output logic wr, output logic [63:0] res, output logic [1:0] err);
        int  f[4];
        int  d[4];
        int  s;
        bit  short_f;
        wr = 1'b0; res = rec; err = 2'd0; short_f = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f[i] = int'(rec >> (52 - 12*i)) & 4095;
            d[i] = int'(dl >> (36 - 12*i)) & 4095;
        end
        if (op == 2'd1) begin
            wr = 1'b1;
            for (int i = 0; i < 4; i++) begin
                s = f[i] + d[i];
                if (s > 4095) begin s = 4095; err = 2'd1; end
                res[63-12*i -: 12] = 12'(s);
            end
        end else if (op == 2'd2) begin
            for (int i = 0; i < 4; i++) if (f[i] < d[i]) short_f = 1'b1;
            if (short_f) err = 2'd2;
            else begin
                wr = 1'b1;
                for (int i = 0; i < 4; i++) res[63-12*i -: 12] = 12'(f[i] - d[i]);
            end
        end
    endfunction

    // Bridge: one command at a time, completes after the programmed latency.
    initial begin
        bit          r;
        logic [7:0]  a;
        logic [63:0] dw;
        int          lat;
        bit          ab;
        bus.C_out_valid = 1'b0;
        bus.C_data_r    = 64'd0;
        forever begin
            @(posedge clk); #1;
            if (!rst && bus.C_in_valid) begin
                r = bus.C_r_wb; a = bus.C_addr; dw = bus.C_data_w;
                lat = r ? rd_lat : wr_lat;
                ab = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk); #1;
                    if (rst) ab = 1'b1;
                    if (ab) break;
                    chk("cmd_while_outstanding", 64'(bus.C_in_valid), 64'd0);
                end
                if (!ab) begin
                    if (r) bus.C_data_r = mem[a];
                    else mem[a] = dw;
                    bus.C_out_valid = 1'b1;
                    @(posedge clk); #1;
                    bus.C_out_valid = 1'b0;
                    bus.C_data_r = {$urandom, $urandom};
                end
            end
        end
    end

    // Compare process: every cycle, against the expected command/response streams.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin cidx = cq.size(); ridx = rq.size(); rsp_cnt = acc_cnt; end
            chk("req_ready", 64'(bus.req_ready), 64'(acc_cnt == rsp_cnt));
            if (bus.C_in_valid) begin
                cmd_cnt++;
                chk("cmd_one_cycle", 64'(c_prev), 64'd0);
                chk("cmd_expected", 64'(cidx < cq.size()), 64'd1);
                if (cidx < cq.size()) begin
                    chk("cmd_r_wb", 64'(bus.C_r_wb), 64'(cq[cidx].rd));
                    chk("cmd_addr", 64'(bus.C_addr), 64'(cq[cidx].a));
                    if (!cq[cidx].rd) chk("cmd_data_w", bus.C_data_w, cq[cidx].d);
                    cidx++;
                end
            end
            c_prev = bus.C_in_valid;
            if (bus.resp_valid) begin
                chk("resp_expected", 64'(ridx < rq.size()), 64'd1);
                if (ridx < rq.size()) begin
                    chk("resp_data", bus.resp_data, rq[ridx].d);
                    chk("resp_err", 64'(bus.resp_err), 64'(rq[ridx].e));
                    ridx++;
                end
                last_data = bus.resp_data;
                last_err  = bus.resp_err;
                rsp_cnt++;
            end else begin
                chk("resp_data_idle", bus.resp_data, 64'd0);
                chk("resp_err_idle", 64'(bus.resp_err), 64'd0);
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [47:0] dl,
                         input int rl, input int wl);
        logic        wr;
        logic [63:0] res;
        logic [1:0]  e;
        int          n = 0;
        model(op, mem[a], dl, wr, res, e);
        cq.push_back('{1'b1, a, 64'd0});
        if (wr) cq.push_back('{1'b0, a, res});
        rq.push_back('{res, e});
        rd_lat = rl; wr_lat = wl;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_delta = dl;
        @(posedge clk); #1 acc_cnt++;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op = 2'($urandom); bus.req_addr = 8'($urandom);
        bus.req_delta = {16'($urandom), $urandom};
        while (acc_cnt != rsp_cnt && n < 3000) begin @(negedge clk); n++; end
        if (acc_cnt != rsp_cnt) begin
            chk("resp_timeout", 64'(acc_cnt != rsp_cnt), 64'd0);
            rst = 1'b1;
            @(negedge clk); @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        int c0, r0;
        logic [47:0] dl;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_addr = 8'd0; bus.req_delta = 48'd0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_c_in_valid", 64'(bus.C_in_valid), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        rst = 1'b0;

        mem[8'h05] = 64'h1234_5678_9ABC_0A1F;
        c0 = cmd_cnt;
        do_op(2'd0, 8'h05, 48'hABC_DEF_123_456, 1, 1);
        chk("read_data", last_data, 64'h1234_5678_9ABC_0A1F);
        chk("read_err", 64'(last_err), 64'd0);
        chk("read_cmds", 64'(cmd_cnt - c0), 64'd1);

        mem[8'h21] = {12'd100, 12'd4000, 12'd0, 12'd4095, 16'hBEEF};
        do_op(2'd1, 8'h21, {12'd5, 12'd200, 12'd7, 12'd1}, 1, 1);
        chk("add_mem", mem[8'h21], 64'h069F_FF00_7FFF_BEEF);
        chk("add_data", last_data, 64'h069F_FF00_7FFF_BEEF);
        chk("add_err", 64'(last_err), 64'd1);

        mem[8'h30] = 64'h00A0_0A00_A00A_1234;
        c0 = cmd_cnt;
        do_op(2'd2, 8'h30, 48'h001_001_00B_001, 2, 2);
        chk("subrej_cmds", 64'(cmd_cnt - c0), 64'd1);
        chk("subrej_data", last_data, 64'h00A0_0A00_A00A_1234);
        chk("subrej_err", 64'(last_err), 64'd2);
        chk("subrej_mem", mem[8'h30], 64'h00A0_0A00_A00A_1234);

        mem[8'h31] = {12'd12, 12'd0, 12'd4095, 12'd3, 16'h5555};
        c0 = cmd_cnt;
        do_op(2'd2, 8'h31, {12'd12, 12'd0, 12'd4095, 12'd3}, 1, 3);
        chk("subok_mem", mem[8'h31], 64'h0000_0000_0000_5555);
        chk("subok_err", 64'(last_err), 64'd0);
        chk("subok_cmds", 64'(cmd_cnt - c0), 64'd2);

        c0 = cmd_cnt; r0 = rsp_cnt;
        do_op(2'd1, 8'h40, 48'h001_002_003_004, 50, 30);
        chk("stall_cmds", 64'(cmd_cnt - c0), 64'd2);
        chk("stall_resps", 64'(rsp_cnt - r0), 64'd1);

        mem[8'h09] = 64'hCAFE_F00D_1357_2468;
        cq.push_back('{1'b1, 8'h09, 64'd0});
        rd_lat = 20;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_addr = 8'h09;
        @(posedge clk); #1 acc_cnt++;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("midrst_c_in_valid", 64'(bus.C_in_valid), 64'd0);
        chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("midrst_resp_data", bus.resp_data, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_req_ready", 64'(bus.req_ready), 64'd1);
        do_op(2'd0, 8'h09, 48'd0, 1, 1);
        chk("postrst_read", last_data, 64'hCAFE_F00D_1357_2468);

        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < 4; i++)
                dl[47-12*i -: 12] = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 15))
                                                               : 12'($urandom_range(0, 4095));
            do_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), dl,
                  $urandom_range(1, 4), $urandom_range(1, 4));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
